// File: rtl/sar_adc_controller.sv
// Successive-approximation sequencer: track/hold, binary-search DAC trials, result latch.
// Optional SAR_ADC_CONTINUOUS_EN: back-to-back conversions while START stays high.
module sar_adc_controller #(
   parameter int unsigned NBITS         = 10,
   parameter int unsigned SAMPLE_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             CMP,
   output logic             SAMPLE,
   output logic [NBITS-1:0] DAC_CODE,
   output logic             BUSY,
   output logic [NBITS-1:0] DATA,
   output logic             EOC
);

   localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONV,
      ST_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] bit_idx;
   logic [NBITS-1:0] work;

   logic [NBITS-1:0] bit_mask_c;
   logic [NBITS-1:0] next_mask_c;
   logic [NBITS-1:0] work_next_c;

   // Trial bit under test, the one below it, and the resolved code after this compare.
   assign bit_mask_c  = NBITS'(1) << bit_idx;
   assign next_mask_c = bit_mask_c >> 1;
   assign work_next_c = CMP ? (work | bit_mask_c) : (work & ~bit_mask_c);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         work     <= '0;
         SAMPLE   <= 1'b0;
         DAC_CODE <= '0;
         BUSY     <= 1'b0;
         DATA     <= '0;
         EOC      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               EOC      <= 1'b0;
               DAC_CODE <= '0;
               if (START) begin
                  state  <= ST_SAMPLE;
                  cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
                  SAMPLE <= 1'b1;
                  BUSY   <= 1'b1;
                  work   <= '0;
               end
            end

            ST_SAMPLE: begin
               if (cnt == '0) begin
                  state    <= ST_CONV;
                  cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                  bit_idx  <= IDX_W'(NBITS - 1);
                  work     <= '0;
                  SAMPLE   <= 1'b0;
                  DAC_CODE <= NBITS'(1) << (NBITS - 1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            // Compare is taken on the last settle cycle of each bit.
            ST_CONV: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  work <= work_next_c;
                  if (bit_idx == '0) begin
                     state    <= ST_DONE;
                     DATA     <= work_next_c;
                     DAC_CODE <= work_next_c;
                     EOC      <= 1'b1;
                  end else begin
                     bit_idx  <= bit_idx - IDX_W'(1);
                     cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                     DAC_CODE <= work_next_c | next_mask_c;
                  end
               end
            end

            ST_DONE: begin
               EOC      <= 1'b0;
               DAC_CODE <= '0;
`ifdef SAR_ADC_CONTINUOUS_EN
               if (START) begin
                  state  <= ST_SAMPLE;
                  cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
                  SAMPLE <= 1'b1;
                  work   <= '0;
               end else begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end
`else
               state <= ST_IDLE;
               BUSY  <= 1'b0;
`endif
            end

            default: begin
               state  <= ST_IDLE;
               SAMPLE <= 1'b0;
               BUSY   <= 1'b0;
               EOC    <= 1'b0;
            end
         endcase
      end
   end

endmodule
